stage_two: RTL and testbench

- Execute stage of the 16-bit pipelined CPU, directly downstream of the fetch/decode stage.
- Consumes the flopped ALU operands, ALU control and pass-through control/instruction fields.
- Computes single-cycle ALU ops, plus iterative signed MUL/DIV through an internal FSM that stalls upstream.
- Registers the 32-bit result and pass-through fields toward stage three; the high word carries the MUL high half or the DIV remainder, used for R0 writes and forwarding.

---
 rtl/stage_two.sv | 237 +++++++++++++++++++++++
 tb/tb_stage_two.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stage_two.sv
// stage_two: execute stage of the 16-bit CPU; single-cycle ALU plus iterative signed MUL/DIV FSM.
// Optional macro STAGE_TWO_EARLY_TERM_EN: MUL leaves RUN once the remaining multiplier bits are zero.
module stage_two #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt_sys,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_alu_a,
  input  logic [DATA_W-1:0]     in_alu_b,
  input  logic [CTRL_W-1:0]     in_alu_ctrl,
  input  logic                  in_reg_wr,
  input  logic                  in_R0_en,
  input  logic [1:0]            in_memc,
  input  logic [DATA_W-1:0]     in_R1_data,
  input  logic [15:0]           in_instr,
  output logic                  stall,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_aluout,
  output logic                  out_reg_wr,
  output logic                  out_R0_en,
  output logic [1:0]            out_memc,
  output logic [DATA_W-1:0]     out_R1_data,
  output logic [15:0]           out_instr,
  output logic                  out_overflow,
  output logic                  out_div0
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int RES_W = 2 * DATA_W;
  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_SLL = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OP_SRL = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] OP_ROL = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OP_ROR = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] OP_DIV = CTRL_W'(9);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIX = 2'd2, ST_DONE = 2'd3} state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [RES_W-1:0]    acc_r, acc_s, mcand_r, mcand_s;
  logic [DATA_W-1:0]   mplier_r, mplier_s;
  logic                is_div_r, is_div_s, sign_a_r, sign_a_s, sign_b_r, sign_b_s;
  logic                div0_r, div0_s, ovf_r, ovf_s, reg_wr_r, reg_wr_s, r0_en_r, r0_en_s;
  logic [1:0]          memc_r, memc_s;
  logic [DATA_W-1:0]   r1_data_r, r1_data_s;
  logic [15:0]         instr_r, instr_s;

  logic                o_valid_s, o_reg_wr_s, o_r0_en_s, o_ovf_s, o_div0_s, stall_s;
  logic [RES_W-1:0]    o_aluout_s;
  logic [1:0]          o_memc_s;
  logic [DATA_W-1:0]   o_r1_data_s;
  logic [15:0]         o_instr_s;

  logic [3:0]          sh_s;
  logic [CNT_W-1:0]    rsh_s;
  logic [DATA_W-1:0]   sum_s, dif_s, rol_s, ror_s, mag_a_s, mag_b_s, quo_fix_s, rem_fix_s;
  logic [RES_W-1:0]    alu_res_s, prod_add_s;
  logic [DATA_W:0]     shifted_s, trial_s;
  logic                alu_ovf_s, illegal_s, is_mul_op_s, is_div_op_s, start_s, run_last_s, sdiff_s;

  assign sh_s    = in_alu_b[3:0];
  assign rsh_s   = CNT_W'(DATA_W) - CNT_W'(sh_s);
  assign sum_s   = in_alu_a + in_alu_b;
  assign dif_s   = in_alu_a - in_alu_b;
  assign rol_s   = (in_alu_a << sh_s) | (in_alu_a >> rsh_s);
  assign ror_s   = (in_alu_a >> sh_s) | (in_alu_a << rsh_s);
  assign mag_a_s = in_alu_a[DATA_W-1] ? -in_alu_a : in_alu_a;
  assign mag_b_s = in_alu_b[DATA_W-1] ? -in_alu_b : in_alu_b;

  assign is_mul_op_s = (in_alu_ctrl == OP_MUL);
  assign is_div_op_s = (in_alu_ctrl == OP_DIV);
  assign start_s     = (state_r == ST_IDLE) && in_valid && (is_mul_op_s || is_div_op_s);

  // Restoring division keeps {remainder, shifting dividend/quotient} in acc_r
  assign shifted_s  = {acc_r[RES_W-1:DATA_W], acc_r[DATA_W-1]};
  assign trial_s    = shifted_s - {1'b0, mplier_r};
  assign prod_add_s = acc_r + mcand_r;
  assign sdiff_s    = sign_a_r ^ sign_b_r;
  assign quo_fix_s  = sdiff_s ? -acc_r[DATA_W-1:0] : acc_r[DATA_W-1:0];
  assign rem_fix_s  = sign_a_r ? -acc_r[RES_W-1:DATA_W] : acc_r[RES_W-1:DATA_W];

`ifdef STAGE_TWO_EARLY_TERM_EN
  assign run_last_s = (cnt_r == CNT_W'(DATA_W - 1)) ||
                      (!is_div_r && (mplier_r[DATA_W-1:1] == {(DATA_W-1){1'b0}}));
`else
  assign run_last_s = (cnt_r == CNT_W'(DATA_W - 1));
`endif

  assign stall = stall_s & rst;

  // Single-cycle ALU result and signed overflow
  always_comb begin
    alu_res_s = {RES_W{1'b0}};
    alu_ovf_s = 1'b0;
    illegal_s = 1'b0;
    case (in_alu_ctrl)
      OP_ADD: begin
        alu_res_s = {{DATA_W{1'b0}}, sum_s};
        alu_ovf_s = (in_alu_a[DATA_W-1] == in_alu_b[DATA_W-1]) && (sum_s[DATA_W-1] != in_alu_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res_s = {{DATA_W{1'b0}}, dif_s};
        alu_ovf_s = (in_alu_a[DATA_W-1] != in_alu_b[DATA_W-1]) && (dif_s[DATA_W-1] != in_alu_a[DATA_W-1]);
      end
      OP_AND:  alu_res_s = {{DATA_W{1'b0}}, in_alu_a & in_alu_b};
      OP_OR:   alu_res_s = {{DATA_W{1'b0}}, in_alu_a | in_alu_b};
      OP_SLL:  alu_res_s = {{DATA_W{1'b0}}, in_alu_a << sh_s};
      OP_SRL:  alu_res_s = {{DATA_W{1'b0}}, in_alu_a >> sh_s};
      OP_ROL:  alu_res_s = {{DATA_W{1'b0}}, rol_s};
      OP_ROR:  alu_res_s = {{DATA_W{1'b0}}, ror_s};
      OP_MUL, OP_DIV: alu_res_s = {RES_W{1'b0}};
      default: illegal_s = 1'b1;
    endcase
  end

  // FSM next state, iterative datapath and next output-register values
  always_comb begin
    state_s = state_r;   cnt_s = cnt_r;       acc_s = acc_r;       mcand_s = mcand_r;
    mplier_s = mplier_r; is_div_s = is_div_r; sign_a_s = sign_a_r; sign_b_s = sign_b_r;
    div0_s = div0_r;     ovf_s = ovf_r;       reg_wr_s = reg_wr_r; r0_en_s = r0_en_r;
    memc_s = memc_r;     r1_data_s = r1_data_r; instr_s = instr_r;
    stall_s = 1'b0;
    o_valid_s = 1'b0;    o_aluout_s = {RES_W{1'b0}}; o_reg_wr_s = 1'b0; o_r0_en_s = 1'b0;
    o_memc_s = 2'b00;    o_r1_data_s = {DATA_W{1'b0}}; o_instr_s = 16'h0000;
    o_ovf_s = 1'b0;      o_div0_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          stall_s   = 1'b1;
          is_div_s  = is_div_op_s;
          sign_a_s  = in_alu_a[DATA_W-1];
          sign_b_s  = in_alu_b[DATA_W-1];
          div0_s    = is_div_op_s && (in_alu_b == {DATA_W{1'b0}});
          ovf_s     = 1'b0;
          cnt_s     = {CNT_W{1'b0}};
          acc_s     = is_div_op_s ? {{DATA_W{1'b0}}, mag_a_s} : {RES_W{1'b0}};
          mcand_s   = {{DATA_W{1'b0}}, mag_a_s};
          mplier_s  = mag_b_s;
          reg_wr_s  = in_reg_wr;
          r0_en_s   = in_R0_en;
          memc_s    = in_memc;
          r1_data_s = in_R1_data;
          instr_s   = in_instr;
          state_s   = div0_s ? ST_DONE : ST_RUN;
        end else begin
          o_valid_s   = in_valid;
          o_aluout_s  = illegal_s ? {RES_W{1'b0}} : alu_res_s;
          o_ovf_s     = alu_ovf_s;
          o_reg_wr_s  = in_reg_wr & ~illegal_s;
          o_r0_en_s   = in_R0_en & ~illegal_s;
          o_memc_s    = in_memc;
          o_r1_data_s = in_R1_data;
          o_instr_s   = in_instr;
        end
      end
      ST_RUN: begin
        stall_s = 1'b1;
        cnt_s   = cnt_r + CNT_W'(1);
        if (is_div_r) begin
          if (!trial_s[DATA_W]) begin
            acc_s = {trial_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
          end else begin
            acc_s = {shifted_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
          end
        end else begin
          acc_s    = mplier_r[0] ? prod_add_s : acc_r;
          mcand_s  = mcand_r << 1;
          mplier_s = mplier_r >> 1;
        end
        state_s = run_last_s ? ST_FIX : ST_RUN;
      end
      ST_FIX: begin
        stall_s = 1'b1;
        if (is_div_r) begin
          acc_s = {rem_fix_s, quo_fix_s};
          ovf_s = !sdiff_s && acc_r[DATA_W-1];
        end else begin
          acc_s = sdiff_s ? -acc_r : acc_r;
          ovf_s = 1'b0;
        end
        state_s = ST_DONE;
      end
      ST_DONE: begin
        o_valid_s   = 1'b1;
        o_aluout_s  = div0_r ? {RES_W{1'b0}} : acc_r;
        o_ovf_s     = ovf_r;
        o_div0_s    = div0_r;
        o_reg_wr_s  = reg_wr_r & ~div0_r;
        o_r0_en_s   = r0_en_r & ~div0_r;
        o_memc_s    = memc_r;
        o_r1_data_s = r1_data_r;
        o_instr_s   = instr_r;
        state_s     = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM and iterative datapath registers; frozen while halt_sys is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;  cnt_r <= {CNT_W{1'b0}};  acc_r <= {RES_W{1'b0}};  mcand_r <= {RES_W{1'b0}};
      mplier_r <= {DATA_W{1'b0}};  is_div_r <= 1'b0;  sign_a_r <= 1'b0;  sign_b_r <= 1'b0;
      div0_r <= 1'b0;  ovf_r <= 1'b0;  reg_wr_r <= 1'b0;  r0_en_r <= 1'b0;  memc_r <= 2'b00;
      r1_data_r <= {DATA_W{1'b0}};  instr_r <= 16'h0000;
    end else if (!halt_sys) begin
      state_r <= state_s;  cnt_r <= cnt_s;  acc_r <= acc_s;  mcand_r <= mcand_s;
      mplier_r <= mplier_s;  is_div_r <= is_div_s;  sign_a_r <= sign_a_s;  sign_b_r <= sign_b_s;
      div0_r <= div0_s;  ovf_r <= ovf_s;  reg_wr_r <= reg_wr_s;  r0_en_r <= r0_en_s;  memc_r <= memc_s;
      r1_data_r <= r1_data_s;  instr_r <= instr_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Output registers toward stage three
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;  out_aluout <= {RES_W{1'b0}};  out_reg_wr <= 1'b0;  out_R0_en <= 1'b0;
      out_memc <= 2'b00;  out_R1_data <= {DATA_W{1'b0}};  out_instr <= 16'h0000;
      out_overflow <= 1'b0;  out_div0 <= 1'b0;
    end else if (!halt_sys) begin
      out_valid <= o_valid_s;  out_aluout <= o_aluout_s;  out_reg_wr <= o_reg_wr_s;  out_R0_en <= o_r0_en_s;
      out_memc <= o_memc_s;  out_R1_data <= o_r1_data_s;  out_instr <= o_instr_s;
      out_overflow <= o_ovf_s;  out_div0 <= o_div0_s;
    end else begin
      out_valid <= out_valid;
    end
  end
endmodule

// File: tb/tb_stage_two.sv
// tb_stage_two: directed scoreboard bench for stage_two (latency, stall length, results, flags).
module tb_stage_two;
`ifdef STAGE_TWO_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int KIND_SINGLE = 0;
  localparam int KIND_MULTI  = 1;
  localparam int KIND_DIV0   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt_sys = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_alu_a = 16'h0000;
  logic [15:0] in_alu_b = 16'h0000;
  logic [3:0]  in_alu_ctrl = 4'h0;
  logic        in_reg_wr = 1'b0;
  logic        in_R0_en = 1'b0;
  logic [1:0]  in_memc = 2'b00;
  logic [15:0] in_R1_data = 16'h0000;
  logic [15:0] in_instr = 16'h0000;
  logic        stall, out_valid, out_reg_wr, out_R0_en, out_overflow, out_div0;
  logic [31:0] out_aluout;
  logic [1:0]  out_memc;
  logic [15:0] out_R1_data, out_instr;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        dz;
    logic        rw;
    logic [15:0] instr;
    int          edges;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;

  stage_two dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_valid(in_valid),
    .in_alu_a(in_alu_a), .in_alu_b(in_alu_b), .in_alu_ctrl(in_alu_ctrl),
    .in_reg_wr(in_reg_wr), .in_R0_en(in_R0_en), .in_memc(in_memc),
    .in_R1_data(in_R1_data), .in_instr(in_instr), .stall(stall),
    .out_valid(out_valid), .out_aluout(out_aluout), .out_reg_wr(out_reg_wr),
    .out_R0_en(out_R0_en), .out_memc(out_memc), .out_R1_data(out_R1_data),
    .out_instr(out_instr), .out_overflow(out_overflow), .out_div0(out_div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // RUN length of an iterative op: DIV and plain MUL take 16; early-term MUL stops at the multiplier MSB
  function automatic int run_len(input logic [15:0] b, input bit is_mul);
    logic [15:0] m;
    int r;
    m = b[15] ? (16'h0000 - b) : b;
    r = 1;
    for (int i = 1; i < 16; i++) if (m[i]) r = i + 1;
    return (is_mul && EARLY) ? r : 16;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] res, input logic ovf,
                        input logic dz, input logic rw, input int kind, input int halt_at);
    exp_t e, g;
    int   n_edge, n_stall, run, hold;
    bit   got, st, hl;
    hold = (halt_at != 0) ? 5 : 0;
    run  = run_len(b, ctrl == 4'd8);
    e.res = res; e.ovf = ovf; e.dz = dz; e.rw = rw; e.instr = {ctrl, a[11:0]};
    if (kind == KIND_SINGLE) begin
      e.edges = 1; e.stalls = 0;
    end else if (kind == KIND_DIV0) begin
      e.edges = 2; e.stalls = 1;
    end else begin
      e.edges = 3 + run + hold; e.stalls = 2 + run + hold;
    end
    sb.push_back(e);
    in_valid = 1'b1; in_alu_a = a; in_alu_b = b; in_alu_ctrl = ctrl;
    in_reg_wr = 1'b1; in_R0_en = 1'b1; in_memc = 2'b10; in_R1_data = ~a; in_instr = {ctrl, a[11:0]};
    n_edge = 0; n_stall = 0; got = 1'b0;
    while (!got && n_edge < 80) begin
      #1;
      st = stall; hl = halt_sys;
      if (st) n_stall++;
      @(posedge clk);
      n_edge++;
      #1;
      if (!st && !hl) in_valid = 1'b0;
      if (halt_at != 0 && n_edge == halt_at) halt_sys = 1'b1;
      if (halt_at != 0 && n_edge == halt_at + 5) halt_sys = 1'b0;
      if (out_valid === 1'b1) begin
        got = 1'b1;
        g = sb.pop_front();
        check({tag, " aluout"},   out_aluout, g.res);
        check({tag, " overflow"}, 32'(out_overflow), 32'(g.ovf));
        check({tag, " div0"},     32'(out_div0), 32'(g.dz));
        check({tag, " reg_wr"},   32'(out_reg_wr), 32'(g.rw));
        check({tag, " R0_en"},    32'(out_R0_en), 32'(g.rw));
        check({tag, " instr"},    32'(out_instr), 32'(g.instr));
        check({tag, " memc"},     32'(out_memc), 32'(2'b10));
        check({tag, " edges"},    32'(n_edge), 32'(g.edges));
        check({tag, " stall_cycles"}, 32'(n_stall), 32'(g.stalls));
      end
    end
    if (!got) begin
      n_assert++;
      assert (got) else begin
        n_fail++;
        $error("FAIL %s timeout: observed no out_valid expected result within %0d edges", tag, n_edge);
      end
      void'(sb.pop_front());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset valid",  32'(out_valid), 32'(1'b0));
    check("reset aluout", out_aluout, 32'h0000_0000);
    check("reset stall",  32'(stall), 32'(1'b0));
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 32'h0000_8000, 1'b1, 1'b0, 1'b1, KIND_SINGLE, 0);
    run_op("sub_neg", 4'd1, 16'h0005, 16'h0007, 32'h0000_FFFE, 1'b0, 1'b0, 1'b1, KIND_SINGLE, 0);
    run_op("and",     4'd2, 16'hF0F0, 16'h0FF0, 32'h0000_00F0, 1'b0, 1'b0, 1'b1, KIND_SINGLE, 0);
    run_op("or",      4'd3, 16'hF000, 16'h000F, 32'h0000_F00F, 1'b0, 1'b0, 1'b1, KIND_SINGLE, 0);
    run_op("sll",     4'd4, 16'h0001, 16'h0004, 32'h0000_0010, 1'b0, 1'b0, 1'b1, KIND_SINGLE, 0);
    run_op("srl",     4'd5, 16'h8000, 16'h000F, 32'h0000_0001, 1'b0, 1'b0, 1'b1, KIND_SINGLE, 0);
    run_op("rol",     4'd6, 16'h8001, 16'h0001, 32'h0000_0003, 1'b0, 1'b0, 1'b1, KIND_SINGLE, 0);
    run_op("rol0",    4'd6, 16'h1234, 16'h0000, 32'h0000_1234, 1'b0, 1'b0, 1'b1, KIND_SINGLE, 0);
    run_op("ror",     4'd7, 16'h0001, 16'h0001, 32'h0000_8000, 1'b0, 1'b0, 1'b1, KIND_SINGLE, 0);
    run_op("illegal", 4'd12, 16'h1111, 16'h2222, 32'h0000_0000, 1'b0, 1'b0, 1'b0, KIND_SINGLE, 0);

    // Reset in the middle of a MUL aborts it
    in_valid = 1'b1; in_alu_a = 16'h0123; in_alu_b = 16'h0456; in_alu_ctrl = 4'd8;
    repeat (3) @(posedge clk);
    #1;
    check("mul_run stall", 32'(stall), 32'(1'b1));
    rst = 1'b0;
    #1;
    check("midreset valid",  32'(out_valid), 32'(1'b0));
    check("midreset aluout", out_aluout, 32'h0000_0000);
    check("midreset stall",  32'(stall), 32'(1'b0));
    check("midreset instr",  32'(out_instr), 32'h0000_0000);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op("add_after_rst", 4'd0, 16'h0002, 16'h0003, 32'h0000_0005, 1'b0, 1'b0, 1'b1, KIND_SINGLE, 0);

    run_op("mul_neg",  4'd8, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b1, KIND_MULTI, 0);
    run_op("mul_min",  4'd8, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 1'b0, 1'b1, KIND_MULTI, 0);
    run_op("div_neg",  4'd9, 16'hFFF9, 16'h0002, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1, KIND_MULTI, 0);
    run_op("div_ovf",  4'd9, 16'h8000, 16'hFFFF, 32'h0000_8000, 1'b1, 1'b0, 1'b1, KIND_MULTI, 0);
    run_op("div_negb", 4'd9, 16'h0007, 16'hFFFE, 32'h0001_FFFD, 1'b0, 1'b0, 1'b1, KIND_MULTI, 0);
    run_op("div0",     4'd9, 16'h1234, 16'h0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, KIND_DIV0, 0);
    run_op("add_clr",  4'd0, 16'h0001, 16'h0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1, KIND_SINGLE, 0);
    run_op("mul_halt", 4'd8, 16'h0010, 16'h0010, 32'h0000_0100, 1'b0, 1'b0, 1'b1, KIND_MULTI, 4);
    run_op("mul_short", 4'd8, 16'h0003, 16'h0001, 32'h0000_0003, 1'b0, 1'b0, 1'b1, KIND_MULTI, 0);

    check("scoreboard empty", 32'(sb.size()), 32'h0000_0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
